palette_ctrl: RTL and testbench
===============================

PALETTE_CTRL -- requirements
Module: palette_ctrl

Interface
REQ-001 Parameter BLANK_COLOR, default 30'h0: color driven when video_on is low.
REQ-002 Port clk  input  1: single clock; all state is on its rising edge.
REQ-003 Port reset  input  1: asynchronous, active-high reset.
REQ-004 Port video_on  input  1: high in the active display area.
REQ-005 Port pix_valid  input  1: pix_in carries a pixel this cycle.
REQ-006 Port pix_in  input  8: pixel index, RRRGGGBB.
REQ-007 Port cpu_wr  input  1: palette write request, accepted only when cpu_busy is low.
REQ-008 Port cpu_addr  input  8: palette entry to write.
REQ-009 Port cpu_data  input  30: new entry, {r10,g10,b10}.
REQ-010 Port cpu_busy  output  1: write path cannot accept a write.
REQ-011 Port color_out  output  30: registered {r10,g10,b10}.
REQ-012 Port color_valid  output  1: color_out is valid this cycle.

Function
REQ-013 Fixed expansion SHALL be: r10={r3,r3,r3,r3[2]}; g10={g3,g3,g3,g3[2]}; b10={b2 repeated five times}.
REQ-014 The pixel path SHALL have exactly 2 cycles of latency: color_valid(t+2)=pix_valid(t), and color_out(t+2) corresponds to pix_in(t) and video_on(t).
REQ-015 When video_on(t) is low, color_out(t+2) SHALL equal BLANK_COLOR.
REQ-016 The FSM SHALL have two states, INIT and RUN; reset enters INIT.
REQ-017 In INIT, an 8-bit counter SHALL write the fixed expansion of each index (0..255) into a 256x30 single-port RAM at one entry per cycle, then go to RUN after entry 255 (256 cycles).
REQ-018 In INIT, cpu_busy SHALL be 1, and pixel lookups SHALL use the fixed expansion.
REQ-019 In RUN, pixel lookups SHALL read the RAM.
REQ-020 An accepted cpu_wr SHALL load a 1-deep pending register {addr,data}, and cpu_busy SHALL be 1 while a write is pending.
REQ-021 A pending write SHALL commit to the RAM in the first RUN cycle where (pix_valid & video_on) is 0; pixel reads always win the RAM port.
REQ-022 cpu_busy SHALL fall in the cycle after commit; a cpu_wr asserted while cpu_busy=1 SHALL be ignored.
REQ-023 A pixel read of an entry whose write is pending SHALL return the old value; any read issued after the commit cycle SHALL return the new value.
REQ-024 A write pending at the end of INIT SHALL remain pending and commit normally in RUN.

Reset
REQ-025 Reset SHALL force color_out=0, color_valid=0, cpu_busy=1, pending cleared, counter=0 and state INIT, including when asserted mid-INIT or mid-RUN.
REQ-026 Pipeline pixels in flight at reset SHALL be discarded and never emerge.

Configuration
REQ-027 With macro PALETTE_CTRL_LUT_EN defined, the RAM, FSM, pending register and CPU path SHALL exist as specified above.
REQ-028 Without PALETTE_CTRL_LUT_EN, color_out SHALL always use the fixed expansion with the same 2-cycle latency, cpu_busy SHALL be 0 out of reset, and cpu_wr SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold: the FSM state enum, the widths PIX_W=8 and COLOR_W=30, and a function for the fixed 3-3-2 expansion.
REQ-030 The RAM SHALL be one sub-module, pal_ram_256x30, with one read/write port and registered read data (1 cycle).

Verification
REQ-031 Reset, then hold pix_valid=1 with pix_in=8'h92 and video_on=1 -> color_out=30'h249926AA from the third cycle onward; cpu_busy stays 1 for 256 cycles, then falls.
REQ-032 In RUN, pix_in=8'hFF -> color_out=30'h3FFFFFFF; pix_in=8'hE0 -> color_out=30'h3FF00000; each exactly 2 cycles later.
REQ-033 In RUN, write addr 8'h05 with data 30'h12345678 during continuous active pixels -> cpu_busy stays 1 and reads of 8'h05 return the default value; drop video_on for 1 cycle -> commit, cpu_busy falls, and the next read of 8'h05 returns 30'h12345678.
REQ-034 Pulse video_on=0 for 3 cycles with pix_valid=1 -> 3 outputs equal BLANK_COLOR, with color_valid=1.
REQ-035 Assert reset for 1 cycle mid-RUN with a write pending -> outputs zero, the write is lost, INIT reruns, and entry 8'h05 reads its default value.
REQ-036 Build without PALETTE_CTRL_LUT_EN and apply a cpu_wr to 8'h00 -> cpu_busy=0, and pix_in=8'h00 still yields 30'h0.

Source files
------------

// File: rtl/palette_ctrl_pkg.sv
// Shared types, widths and the fixed 3-3-2 to 10-10-10 color expansion for palette_ctrl.
package palette_ctrl_pkg;

    localparam int PIX_W   = 8;
    localparam int COLOR_W = 30;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit replication stretches each channel to full scale, so 0 maps to 0 and all-ones to all-ones.
    function automatic logic [COLOR_W-1:0] expand_332(input logic [PIX_W-1:0] pix);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = pix[7:5];
        g = pix[4:2];
        b = pix[1:0];
        return {r, r, r, r[2], g, g, g, g[2], {5{b}}};
    endfunction

endpackage

// File: rtl/pal_ram_256x30.sv
// 256 x 30 single-port palette RAM with registered read data; a write cycle does not update rdata.
module pal_ram_256x30
    import palette_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [PIX_W-1:0]   addr,
    input  logic [COLOR_W-1:0] wdata,
    output logic [COLOR_W-1:0] rdata
);

    logic [COLOR_W-1:0] mem [256];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/palette_ctrl.sv
// Pixel index to 30-bit color with a fixed 2-cycle latency.
// Define PALETTE_CTRL_LUT_EN to add the CPU-writable palette RAM; otherwise the fixed expansion is used.
module palette_ctrl
    import palette_ctrl_pkg::*;
#(
    parameter logic [COLOR_W-1:0] BLANK_COLOR = 30'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               cpu_wr,
    input  logic [PIX_W-1:0]   cpu_addr,
    input  logic [COLOR_W-1:0] cpu_data,
    output logic               cpu_busy,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_valid
);

    logic               valid_q;
    logic               on_q;
    logic [COLOR_W-1:0] fixed_q;
    logic [COLOR_W-1:0] pix_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            on_q    <= 1'b0;
            fixed_q <= '0;
        end else begin
            valid_q <= pix_valid;
            on_q    <= video_on;
            fixed_q <= expand_332(pix_in);
        end
    end

`ifdef PALETTE_CTRL_LUT_EN
    state_t             state;
    state_t             state_nxt;
    logic [PIX_W-1:0]   init_cnt;
    logic               pend_q;
    logic [PIX_W-1:0]   pend_addr;
    logic [COLOR_W-1:0] pend_data;
    logic               lut_q;
    logic               pix_rd;
    logic               accept;
    logic               commit;
    logic               ram_en;
    logic               ram_we;
    logic [PIX_W-1:0]   ram_addr;
    logic [COLOR_W-1:0] ram_wdata;
    logic [COLOR_W-1:0] ram_rdata;

    assign pix_rd   = pix_valid & video_on;
    assign cpu_busy = (state == INIT) | pend_q;
    assign accept   = cpu_wr & ~cpu_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel reads own the port; a pending write only slips into idle RUN cycles.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = pix_in;
        ram_wdata = pend_data;
        case (state)
            INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = init_cnt;
                ram_wdata = expand_332(init_cnt);
                if (init_cnt == 8'hFF) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (pix_rd) begin
                    ram_en = 1'b1;
                end else if (pend_q) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = pend_addr;
                    commit   = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt  <= '0;
            pend_q    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            lut_q     <= 1'b0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 8'd1;
            end
            if (accept) begin
                pend_q    <= 1'b1;
                pend_addr <= cpu_addr;
                pend_data <= cpu_data;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
            lut_q <= (state == RUN);
        end
    end

    pal_ram_256x30 u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign pix_color = lut_q ? ram_rdata : fixed_q;
`else
    logic unused_cpu;

    assign unused_cpu = ^{cpu_wr, cpu_addr, cpu_data};
    assign cpu_busy   = 1'b0;
    assign pix_color  = fixed_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            color_out   <= on_q ? pix_color : BLANK_COLOR;
            color_valid <= valid_q;
        end
    end

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed self-checking bench for palette_ctrl; covers the PALETTE_CTRL_LUT_EN build and the default build.
module tb_palette_ctrl;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        video_on  = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in    = 8'h00;
    logic        cpu_wr    = 1'b0;
    logic [7:0]  cpu_addr  = 8'h00;
    logic [29:0] cpu_data  = 30'h0;
    logic        cpu_busy;
    logic [29:0] color_out;
    logic        color_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    palette_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_busy    (cpu_busy),
        .color_out   (color_out),
        .color_valid (color_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic on, input logic [7:0] p);
        pix_valid = v;
        video_on  = on;
        pix_in    = p;
    endtask

    task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) tick();
        check("rst_color", color_out, 30'h0);
        check("rst_valid", 30'(color_valid), 30'd0);

`ifdef PALETTE_CTRL_LUT_EN
        check("rst_busy", 30'(cpu_busy), 30'd1);

        // INIT: 256 busy cycles, fixed expansion meanwhile, then RAM lookups
        reset = 1'b0;
        drive(1'b1, 1'b1, 8'h92);
        for (int i = 1; i <= 262; i++) begin
            tick();
            check("init_busy", 30'(cpu_busy), (i < 256) ? 30'd1 : 30'd0);
            if (i == 1) begin
                check("first_valid", 30'(color_valid), 30'd0);
            end else begin
                check("init_color", color_out, 30'h249926AA);
                check("init_valid", 30'(color_valid), 30'd1);
            end
        end

        drive(1'b1, 1'b1, 8'hFF);
        tick();
        check("ff_lat1", color_out, 30'h249926AA);
        tick();
        check("ff", color_out, 30'h3FFFFFFF);
        drive(1'b1, 1'b1, 8'hE0);
        tick();
        check("e0_lat1", color_out, 30'h3FFFFFFF);
        tick();
        check("e0", color_out, 30'h3FF00000);

        // write 0x05 while pixels keep the port busy
        drive(1'b1, 1'b1, 8'h05);
        cpu_wr = 1'b1; cpu_addr = 8'h05; cpu_data = 30'h12345678;
        tick();
        cpu_wr = 1'b0;
        check("wr_busy", 30'(cpu_busy), 30'd1);
        tick();
        check("pend_old0", color_out, 30'h0024955);
        cpu_wr = 1'b1; cpu_data = 30'h0AAAAAAA;
        tick();
        cpu_wr = 1'b0;
        check("pend_old1", color_out, 30'h0024955);
        check("ign_busy", 30'(cpu_busy), 30'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pend_old", color_out, 30'h0024955);
            check("pend_busy", 30'(cpu_busy), 30'd1);
        end
        video_on = 1'b0;
        tick();
        check("commit_busy", 30'(cpu_busy), 30'd0);
        video_on = 1'b1;
        tick();
        check("commit_blank", color_out, 30'h0);
        check("commit_valid", 30'(color_valid), 30'd1);
        tick();
        check("new_val", color_out, 30'h12345678);

        // three blanked cycles
        drive(1'b1, 1'b0, 8'h05);
        tick();
        check("new_val2", color_out, 30'h12345678);
        tick();
        check("blank0", color_out, 30'h0);
        check("blank0_v", 30'(color_valid), 30'd1);
        tick();
        check("blank1", color_out, 30'h0);
        check("blank1_v", 30'(color_valid), 30'd1);
        drive(1'b1, 1'b1, 8'h05);
        tick();
        check("blank2", color_out, 30'h0);
        check("blank2_v", 30'(color_valid), 30'd1);
        check("blank_busy", 30'(cpu_busy), 30'd0);
        tick();
        check("after_blank", color_out, 30'h12345678);
        drive(1'b0, 1'b1, 8'h05);
        tick();
        check("nv_prev", 30'(color_valid), 30'd1);
        tick();
        check("nv", 30'(color_valid), 30'd0);

        // reset mid-RUN with a write pending
        drive(1'b1, 1'b1, 8'h05);
        cpu_wr = 1'b1; cpu_addr = 8'h05; cpu_data = 30'h3FFFFFFF;
        tick();
        cpu_wr = 1'b0;
        check("pend2_busy", 30'(cpu_busy), 30'd1);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_color", color_out, 30'h0);
        check("mid_rst_valid", 30'(color_valid), 30'd0);
        check("mid_rst_busy", 30'(cpu_busy), 30'd1);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i <= 2) begin
                check("flush_valid", 30'(color_valid), 30'd0);
            end
            if (i >= 254) begin
                check("reinit_busy", 30'(cpu_busy), (i < 256) ? 30'd1 : 30'd0);
            end
        end
        drive(1'b1, 1'b1, 8'h05);
        tick();
        tick();
        check("lost_write", color_out, 30'h0024955);
        check("lost_busy", 30'(cpu_busy), 30'd0);
`else
        reset = 1'b0;
        check("busy_out_rst", 30'(cpu_busy), 30'd0);
        drive(1'b1, 1'b1, 8'h92);
        tick();
        check("first_valid", 30'(color_valid), 30'd0);
        tick();
        check("c92", color_out, 30'h249926AA);
        check("c92_v", 30'(color_valid), 30'd1);
        drive(1'b1, 1'b1, 8'hFF);
        tick();
        check("ff_lat1", color_out, 30'h249926AA);
        tick();
        check("ff", color_out, 30'h3FFFFFFF);
        drive(1'b1, 1'b1, 8'hE0);
        tick();
        tick();
        check("e0", color_out, 30'h3FF00000);
        drive(1'b1, 1'b1, 8'h05);
        tick();
        tick();
        check("c05", color_out, 30'h0024955);

        drive(1'b1, 1'b1, 8'h00);
        cpu_wr = 1'b1; cpu_addr = 8'h00; cpu_data = 30'h3FFFFFFF;
        tick();
        cpu_wr = 1'b0;
        check("wr_busy", 30'(cpu_busy), 30'd0);
        tick();
        check("c00", color_out, 30'h0);
        tick();
        check("c00_again", color_out, 30'h0);
        check("busy_after", 30'(cpu_busy), 30'd0);

        drive(1'b1, 1'b0, 8'hFF);
        tick();
        tick();
        check("blank0", color_out, 30'h0);
        check("blank0_v", 30'(color_valid), 30'd1);
        drive(1'b1, 1'b1, 8'hFF);
        tick();
        check("blank1", color_out, 30'h0);
        tick();
        check("unblank", color_out, 30'h3FFFFFFF);
        drive(1'b0, 1'b1, 8'hFF);
        tick();
        tick();
        check("nv", 30'(color_valid), 30'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
